// File: rtl/lsu_tlbwrdp_pkg.sv
// Shared definitions for the DTLB write datapath: STLB tag/data bit positions,
// TTE page-size encodings and the write-request state machine encoding.
package lsu_tlbwrdp_pkg;

   localparam int STLB_TAG_W  = 59;
   localparam int STLB_DATA_W = 43;

   // STLB tag layout; bits 58:55 and 24 are unused
   localparam int STLB_TAG_PARITY      = 54;
   localparam int STLB_TAG_VA_47_21_HI = 53;
   localparam int STLB_TAG_VA_47_21_LO = 27;
   localparam int STLB_TAG_V           = 26;
   localparam int STLB_TAG_U           = 25;
   localparam int STLB_TAG_VA_20_13_HI = 23;
   localparam int STLB_TAG_VA_20_13_LO = 16;
   localparam int STLB_TAG_VA_27_22_V  = 15;
   localparam int STLB_TAG_VA_21_16_V  = 14;
   localparam int STLB_TAG_VA_15_13_V  = 13;
   localparam int STLB_TAG_CTXT_HI     = 12;
   localparam int STLB_TAG_CTXT_LO     = 0;

   // V is left out of the read-side parity so a demap can clear it in place
   localparam logic [STLB_TAG_W-1:0] STLB_TAG_PARITY_MASK =
      ~((59'd1 << STLB_TAG_PARITY) | (59'd1 << STLB_TAG_V) | (59'd1 << 24));

   // STLB data layout; bits 12:10 and 0 are unused
   localparam int STLB_DATA_PARITY        = 42;
   localparam int STLB_DATA_NFO           = 41;
   localparam int STLB_DATA_IE            = 40;
   localparam int STLB_DATA_PA_39_13_HI   = 39;
   localparam int STLB_DATA_PA_39_13_LO   = 13;
   localparam int STLB_DATA_27_22_SEL     = 9;
   localparam int STLB_DATA_21_16_SEL     = 8;
   localparam int STLB_DATA_15_13_SEL     = 7;
   localparam int STLB_DATA_L             = 6;
   localparam int STLB_DATA_W_BIT         = 1;

   localparam logic [2:0] PGSZ_8K   = 3'b000;
   localparam logic [2:0] PGSZ_64K  = 3'b001;
   localparam logic [2:0] PGSZ_4M   = 3'b011;
   localparam logic [2:0] PGSZ_256M = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FMT  = 2'd1,
      ST_REQ  = 2'd2
   } wr_state_e;

endpackage

// File: rtl/lsu_tte_fmt.sv
// Combinational TTE formatter: architectural 64-bit TTE plus tag-access value
// into STLB tag/data words with mux selects, valid masks and parity.
module lsu_tte_fmt
   import lsu_tlbwrdp_pkg::*;
(
   input  logic [63:0]            tte,
   input  logic [63:0]            tag_acc,
   output logic [STLB_TAG_W-1:0]  tag,
   output logic [STLB_DATA_W-1:0] data,
   output logic                   sz_err
);

   logic [2:0] sz;
   logic [2:0] sel;
   logic       unused_fmt_bits;

   assign sz = {tte[48], tte[62:61]};
   assign unused_fmt_bits = ^{tte[58:49], tte[46:40], tte[12:7], tte[0], tag_acc[63:48]};

   always_comb begin
      sel    = 3'b000;
      sz_err = 1'b0;
      case (sz)
         PGSZ_8K:   sel = 3'b000;
         PGSZ_64K:  sel = 3'b001;
         PGSZ_4M:   sel = 3'b011;
         PGSZ_256M: sel = 3'b111;
         default:   sz_err = 1'b1;
      endcase
   end

   always_comb begin
      data = '0;
      data[STLB_DATA_NFO] = tte[60];
      data[STLB_DATA_IE]  = tte[59];
      data[STLB_DATA_PA_39_13_HI:STLB_DATA_PA_39_13_LO] = tte[39:13];
      data[STLB_DATA_27_22_SEL] = sel[2];
      data[STLB_DATA_21_16_SEL] = sel[1];
      data[STLB_DATA_15_13_SEL] = sel[0];
      data[STLB_DATA_L:STLB_DATA_W_BIT] = tte[6:1];
      data[STLB_DATA_PARITY] = ^data[STLB_DATA_PARITY-1:0];
   end

   // VA bits below the page size are masked out of the compare
   always_comb begin
      tag = '0;
      tag[STLB_TAG_V] = tte[63];
      tag[STLB_TAG_U] = tte[47];
      tag[STLB_TAG_VA_47_21_HI:STLB_TAG_VA_47_21_LO] = tag_acc[47:21];
      tag[STLB_TAG_VA_20_13_HI:STLB_TAG_VA_20_13_LO] = tag_acc[20:13];
      tag[STLB_TAG_VA_27_22_V] = ~sel[2];
      tag[STLB_TAG_VA_21_16_V] = ~sel[1];
      tag[STLB_TAG_VA_15_13_V] = ~sel[0];
      tag[STLB_TAG_CTXT_HI:STLB_TAG_CTXT_LO] = tag_acc[12:0];
      tag[STLB_TAG_PARITY] = ^(tag & STLB_TAG_PARITY_MASK);
   end

endmodule

// File: rtl/lsu_tlbwrdp.sv
// DTLB write datapath: per-thread tag-access registers, TTE write accept,
// formatting stage and a held write request to the TLB array.
module lsu_tlbwrdp
   import lsu_tlbwrdp_pkg::*;
#(
   parameter int THREADS = 4,
   parameter int ENTRY_W = 6
)(
   input  logic                   rclk,
   input  logic                   reset,
   input  logic [1:0]             asi_tid,
   input  logic [63:0]            asi_wr_data,
   input  logic                   asi_tag_acc_we,
   input  logic                   asi_data_in_we,
   input  logic                   asi_data_acc_we,
   input  logic [ENTRY_W-1:0]     asi_entry_idx,
   input  logic                   tlb_wr_ack,
   output logic                   tlb_wr_vld,
   output logic [STLB_TAG_W-1:0]  tlb_wr_tte_tag,
   output logic [STLB_DATA_W-1:0] tlb_wr_tte_data,
   output logic                   tlb_wr_idx_vld,
   output logic [ENTRY_W-1:0]     tlb_wr_entry_idx,
   output logic                   tlb_wr_busy,
   output logic                   tlb_wr_done,
   output logic [1:0]             tlb_wr_done_tid,
   output logic                   tlb_wr_sz_err
);

   wr_state_e              state;
   wr_state_e              state_nxt;
   logic [63:0]            tag_acc [THREADS];
   logic [63:0]            cap_tte;
   logic [63:0]            cap_tag_acc;
   logic [1:0]             cap_tid;
   logic [STLB_TAG_W-1:0]  fmt_tag;
   logic [STLB_DATA_W-1:0] fmt_data;
   logic                   fmt_sz_err;
   logic                   accept;

   assign accept = (state == ST_IDLE) && (asi_data_in_we || asi_data_acc_we);

   always_ff @(posedge rclk) begin
      if (reset) begin
         for (int t = 0; t < THREADS; t++) begin
            tag_acc[t] <= '0;
         end
      end else if (asi_tag_acc_we) begin
         tag_acc[asi_tid] <= asi_wr_data;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_FMT;
         ST_FMT:  state_nxt = ST_REQ;
         ST_REQ:  if (tlb_wr_ack) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The tag-access snapshot reads the register before any same-cycle update
   always_ff @(posedge rclk) begin
      if (reset) begin
         state            <= ST_IDLE;
         cap_tte          <= '0;
         cap_tag_acc      <= '0;
         cap_tid          <= '0;
         tlb_wr_idx_vld   <= 1'b0;
         tlb_wr_entry_idx <= '0;
         tlb_wr_tte_tag   <= '0;
         tlb_wr_tte_data  <= '0;
         tlb_wr_sz_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cap_tte          <= asi_wr_data;
            cap_tag_acc      <= tag_acc[asi_tid];
            cap_tid          <= asi_tid;
            tlb_wr_idx_vld   <= asi_data_acc_we;
            tlb_wr_entry_idx <= asi_data_acc_we ? asi_entry_idx : '0;
         end
         if (state == ST_FMT) begin
            tlb_wr_tte_tag  <= fmt_tag;
            tlb_wr_tte_data <= fmt_data;
            if (fmt_sz_err) tlb_wr_sz_err <= 1'b1;
         end
      end
   end

   lsu_tte_fmt u_fmt (
      .tte     (cap_tte),
      .tag_acc (cap_tag_acc),
      .tag     (fmt_tag),
      .data    (fmt_data),
      .sz_err  (fmt_sz_err)
   );

   assign tlb_wr_vld      = (state == ST_REQ);
   assign tlb_wr_busy     = (state != ST_IDLE);
   assign tlb_wr_done     = (state == ST_REQ) && tlb_wr_ack && !reset;
   assign tlb_wr_done_tid = tlb_wr_done ? cap_tid : 2'b00;

endmodule

// File: tb/tb_lsu_tlbwrdp.sv
// Self-checking bench for lsu_tlbwrdp: directed and random TTE writes checked
// against a field-level model of the STLB tag/data formats.
module tb_lsu_tlbwrdp;

   logic        rclk = 1'b0;
   logic        reset;
   logic [1:0]  asi_tid;
   logic [63:0] asi_wr_data;
   logic        asi_tag_acc_we;
   logic        asi_data_in_we;
   logic        asi_data_acc_we;
   logic [5:0]  asi_entry_idx;
   logic        tlb_wr_ack;
   logic        tlb_wr_vld;
   logic [58:0] tlb_wr_tte_tag;
   logic [42:0] tlb_wr_tte_data;
   logic        tlb_wr_idx_vld;
   logic [5:0]  tlb_wr_entry_idx;
   logic        tlb_wr_busy;
   logic        tlb_wr_done;
   logic [1:0]  tlb_wr_done_tid;
   logic        tlb_wr_sz_err;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] model_ta [4];
   logic        exp_sz_err;

   lsu_tlbwrdp #(.THREADS(4), .ENTRY_W(6)) dut (
      .rclk             (rclk),
      .reset            (reset),
      .asi_tid          (asi_tid),
      .asi_wr_data      (asi_wr_data),
      .asi_tag_acc_we   (asi_tag_acc_we),
      .asi_data_in_we   (asi_data_in_we),
      .asi_data_acc_we  (asi_data_acc_we),
      .asi_entry_idx    (asi_entry_idx),
      .tlb_wr_ack       (tlb_wr_ack),
      .tlb_wr_vld       (tlb_wr_vld),
      .tlb_wr_tte_tag   (tlb_wr_tte_tag),
      .tlb_wr_tte_data  (tlb_wr_tte_data),
      .tlb_wr_idx_vld   (tlb_wr_idx_vld),
      .tlb_wr_entry_idx (tlb_wr_entry_idx),
      .tlb_wr_busy      (tlb_wr_busy),
      .tlb_wr_done      (tlb_wr_done),
      .tlb_wr_done_tid  (tlb_wr_done_tid),
      .tlb_wr_sz_err    (tlb_wr_sz_err)
   );

   always #5 rclk = ~rclk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Page-size lookup straight from the encoding table
   function automatic logic [2:0] sel_of(input logic [2:0] sz);
      case (sz)
         3'd0:    return 3'b000;
         3'd1:    return 3'b001;
         3'd3:    return 3'b011;
         3'd5:    return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit sz_reserved(input logic [2:0] sz);
      return !(sz == 3'd0 || sz == 3'd1 || sz == 3'd3 || sz == 3'd5);
   endfunction

   function automatic logic [2:0] sz_of(input logic [63:0] tte);
      return {tte[48], tte[62:61]};
   endfunction

   function automatic logic [63:0] with_sz(input logic [63:0] r, input logic [2:0] sz);
      logic [63:0] t;
      t = r;
      t[48] = sz[2];
      t[62:61] = sz[1:0];
      return t;
   endfunction

   function automatic bit tag_covered(input int i);
      return !(i == 54 || i == 26 || i == 24);
   endfunction

   // Read-side parity check as the array reader would do it
   function automatic bit tag_par_ok(input logic [58:0] t);
      bit p;
      p = 1'b0;
      for (int i = 0; i < 59; i++) if (tag_covered(i)) p ^= t[i];
      return p == t[54];
   endfunction

   function automatic logic [58:0] model_tag(input logic [63:0] tte, input logic [63:0] ta);
      logic [2:0]  s;
      logic [58:0] t;
      s = sel_of(sz_of(tte));
      t = {4'b0, 1'b0, ta[47:21], tte[63], tte[47], 1'b0, ta[20:13],
           ~s[2], ~s[1], ~s[0], ta[12:0]};
      t[54] = 1'b0;
      for (int i = 0; i < 59; i++) if (tag_covered(i)) t[54] = t[54] ^ t[i];
      return t;
   endfunction

   function automatic logic [42:0] model_data(input logic [63:0] tte);
      logic [2:0]  s;
      logic [42:0] d;
      s = sel_of(sz_of(tte));
      d = {1'b0, tte[60], tte[59], tte[39:13], 3'b000, s, tte[6:1], 1'b0};
      d[42] = ^d[41:0];
      return d;
   endfunction

   task automatic cycle();
      @(posedge rclk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic writeTagAcc(input logic [1:0] tid, input logic [63:0] val);
      asi_tid        = tid;
      asi_wr_data    = val;
      asi_tag_acc_we = 1'b1;
      cycle();
      asi_tag_acc_we = 1'b0;
      model_ta[tid]  = val;
   endtask

   // mode 0 = data-in, 1 = data-access, 2 = both (data-access wins)
   task automatic applyStimulus(input int mode, input logic [1:0] tid, input logic [5:0] idx,
                                input logic [63:0] tte, input int ack_delay,
                                input bit tag_clash, input bit busy_poke);
      logic [58:0] exp_tag;
      logic [42:0] exp_data;
      bit          is_acc;
      exp_tag  = model_tag(tte, model_ta[tid]);
      exp_data = model_data(tte);
      is_acc   = (mode != 0);
      asi_tid         = tid;
      asi_wr_data     = tte;
      asi_entry_idx   = idx;
      asi_data_in_we  = (mode != 1);
      asi_data_acc_we = (mode != 0);
      asi_tag_acc_we  = tag_clash;
      cycle();
      if (tag_clash) model_ta[tid] = tte;
      asi_data_in_we  = 1'b0;
      asi_data_acc_we = 1'b0;
      asi_tag_acc_we  = 1'b0;
      if (busy_poke) begin
         asi_tid         = tid ^ 2'd1;
         asi_wr_data     = ~tte;
         asi_entry_idx   = ~idx;
         asi_data_acc_we = 1'b1;
      end
      checkOutput("busy_fmt", tlb_wr_busy, 1);
      checkOutput("vld_fmt", tlb_wr_vld, 0);
      cycle();
      if (sz_reserved(sz_of(tte))) exp_sz_err = 1'b1;
      checkOutput("vld_req", tlb_wr_vld, 1);
      checkOutput("tag_req", tlb_wr_tte_tag, exp_tag);
      checkOutput("data_req", tlb_wr_tte_data, exp_data);
      checkOutput("idx_vld", tlb_wr_idx_vld, is_acc);
      if (is_acc) checkOutput("entry_idx", tlb_wr_entry_idx, idx);
      checkOutput("sz_err", tlb_wr_sz_err, exp_sz_err);
      checkOutput("rd_tag_par", tag_par_ok(tlb_wr_tte_tag), 1);
      checkOutput("rd_tag_par_flip", tag_par_ok(tlb_wr_tte_tag ^ (59'd1 << 30)), 0);
      checkOutput("rd_data_par", ^tlb_wr_tte_data, 0);
      for (int k = 0; k < ack_delay; k++) begin
         checkOutput("done_hold", tlb_wr_done, 0);
         cycle();
         checkOutput("vld_hold", tlb_wr_vld, 1);
         checkOutput("busy_hold", tlb_wr_busy, 1);
         checkOutput("tag_hold", tlb_wr_tte_tag, exp_tag);
         checkOutput("data_hold", tlb_wr_tte_data, exp_data);
      end
      asi_data_acc_we = 1'b0;
      tlb_wr_ack = 1'b1;
      #1;
      checkOutput("done_ack", tlb_wr_done, 1);
      checkOutput("done_tid", tlb_wr_done_tid, tid);
      cycle();
      tlb_wr_ack = 1'b0;
      #1;
      checkOutput("vld_after", tlb_wr_vld, 0);
      checkOutput("busy_after", tlb_wr_busy, 0);
      checkOutput("done_after", tlb_wr_done, 0);
   endtask

   initial begin
      logic [63:0] tte;
      logic [2:0]  sz;
      reset = 1'b1;
      asi_tid = '0;
      asi_wr_data = '0;
      asi_tag_acc_we = 1'b0;
      asi_data_in_we = 1'b0;
      asi_data_acc_we = 1'b0;
      asi_entry_idx = '0;
      tlb_wr_ack = 1'b0;
      exp_sz_err = 1'b0;
      for (int t = 0; t < 4; t++) model_ta[t] = '0;
      repeat (3) cycle();
      reset = 1'b0;

      checkOutput("rst_vld", tlb_wr_vld, 0);
      checkOutput("rst_busy", tlb_wr_busy, 0);
      checkOutput("rst_done", tlb_wr_done, 0);
      checkOutput("rst_sz_err", tlb_wr_sz_err, 0);
      checkOutput("rst_tag", tlb_wr_tte_tag, 0);
      checkOutput("rst_data", tlb_wr_tte_data, 0);
      checkOutput("rst_idx_vld", tlb_wr_idx_vld, 0);

      // Stray ack while idle must not produce a completion
      tlb_wr_ack = 1'b1;
      #1;
      checkOutput("idle_ack_done", tlb_wr_done, 0);
      cycle();
      tlb_wr_ack = 1'b0;
      checkOutput("idle_ack_vld", tlb_wr_vld, 0);

      $display("[TB] 8K data-in write, thread 0");
      writeTagAcc(2'd0, 64'h0000_1234_5678_A005);
      applyStimulus(0, 2'd0, 6'h00, 64'h8000_0012_3456_6006, 0, 1'b0, 1'b0);

      $display("[TB] 256M data-access write to entry 0x3F");
      writeTagAcc(2'd1, {$urandom, $urandom});
      tte = with_sz({$urandom, $urandom}, 3'b101);
      applyStimulus(1, 2'd1, 6'h3F, tte, 0, 1'b0, 1'b0);
      checkOutput("va_v_256m", tlb_wr_tte_tag[15:13], 0);

      $display("[TB] ack held off 5 cycles");
      writeTagAcc(2'd3, {$urandom, $urandom});
      applyStimulus(0, 2'd3, 6'h00, with_sz({$urandom, $urandom}, 3'b001), 5, 1'b0, 1'b0);

      $display("[TB] same-cycle tag-access write on thread 2");
      writeTagAcc(2'd2, {$urandom, $urandom});
      applyStimulus(0, 2'd2, 6'h00, with_sz({$urandom, $urandom}, 3'b011), 1, 1'b1, 1'b0);
      applyStimulus(1, 2'd2, 6'h15, with_sz({$urandom, $urandom}, 3'b000), 0, 1'b0, 1'b0);

      $display("[TB] TTE write while busy is dropped");
      applyStimulus(0, 2'd1, 6'h00, with_sz({$urandom, $urandom}, 3'b000), 2, 1'b0, 1'b1);
      cycle();
      checkOutput("poke_vld", tlb_wr_vld, 0);
      checkOutput("poke_busy", tlb_wr_busy, 0);

      $display("[TB] both TTE write enables, data-access wins");
      applyStimulus(2, 2'd3, 6'h2A, with_sz({$urandom, $urandom}, 3'b101), 0, 1'b0, 1'b0);

      $display("[TB] reserved page size sets sticky error");
      applyStimulus(0, 2'd0, 6'h00, with_sz({$urandom, $urandom}, 3'b010), 0, 1'b0, 1'b0);
      checkOutput("rsvd_sels", tlb_wr_tte_data[9:7], 0);
      applyStimulus(1, 2'd0, 6'h07, with_sz({$urandom, $urandom}, 3'b001), 0, 1'b0, 1'b0);

      $display("[TB] random writes");
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 1) == 1) writeTagAcc(2'($urandom_range(0, 3)), {$urandom, $urandom});
         sz = 3'($urandom_range(0, 7));
         applyStimulus(int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 6'($urandom),
                       with_sz({$urandom, $urandom}, sz), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] reset while request is pending");
      asi_tid        = 2'd1;
      asi_wr_data    = with_sz({$urandom, $urandom}, 3'b000);
      asi_data_in_we = 1'b1;
      cycle();
      asi_data_in_we = 1'b0;
      cycle();
      checkOutput("pre_rst_vld", tlb_wr_vld, 1);
      reset      = 1'b1;
      tlb_wr_ack = 1'b1;
      #1;
      checkOutput("rst_req_done", tlb_wr_done, 0);
      cycle();
      reset      = 1'b0;
      tlb_wr_ack = 1'b0;
      for (int t = 0; t < 4; t++) model_ta[t] = '0;
      exp_sz_err = 1'b0;
      checkOutput("rst_req_vld", tlb_wr_vld, 0);
      checkOutput("rst_req_busy", tlb_wr_busy, 0);
      checkOutput("rst_req_sz_err", tlb_wr_sz_err, 0);
      applyStimulus(1, 2'd1, 6'h11, with_sz({$urandom, $urandom}, 3'b011), 1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_tlbwrdp.md
Name: lsu_tlbwrdp

Overview:
- Write-side datapath for the DTLB. It is the counterpart to the TLB read-formatting/parity-check path.
- Accepts ASI stores to the per-thread tag-access register, the data-in register and the data-access register.
- Converts the architectural 64-bit TTE into the internal STLB tag (59b) and data (43b) formats, and generates the mux-select, valid and parity bits.
- Issues one held write request to the TLB array and waits for its acknowledge.

Parameters:
- THREADS, 4, number of hardware threads (tag-access copies).
- ENTRY_W, 6, TLB entry index width (64 entries).

Ports:
- rclk  in  1  clock
- reset  in  1  synchronous active-high reset
- asi_tid  in  2  thread of current ASI store
- asi_wr_data  in  64  ASI store data
- asi_tag_acc_we  in  1  write tag-access reg[asi_tid] = {VA[63:13],CTXT[12:0]}
- asi_data_in_we  in  1  TTE write, replacement-selected entry
- asi_data_acc_we  in  1  TTE write, explicit entry asi_entry_idx
- asi_entry_idx  in  ENTRY_W  entry for data-access write
- tlb_wr_ack  in  1  array accepted write this cycle
- tlb_wr_vld  out  1  write request to array
- tlb_wr_tte_tag  out  59  formatted tag
- tlb_wr_tte_data  out  43  formatted data
- tlb_wr_idx_vld  out  1  1 = use tlb_wr_entry_idx, 0 = replacement
- tlb_wr_entry_idx  out  ENTRY_W  target entry
- tlb_wr_busy  out  1  write in flight; ASI ctl must not issue new TTE write
- tlb_wr_done  out  1  one-cycle pulse on ack
- tlb_wr_done_tid  out  2  thread of completed write
- tlb_wr_sz_err  out  1  sticky: reserved page size seen; cleared by reset

Behaviour:
- Reset: state IDLE; all outputs 0; tag-access regs 0.
- Tag-access write:
  - Takes effect next cycle and is allowed in any state.
  - A write to the same thread as an in-flight TTE write does not alter it, because the tag is snapshotted at accept.
- Accept occurs in IDLE when asi_data_in_we|asi_data_acc_we.
  - Both asserted: data_acc wins.
  - Captured: data, tid, idx, idx_vld, and tag-access[tid] (same-cycle tag-access write to that tid is NOT seen).
- States:
  - IDLE->FMT on accept.
  - FMT->REQ next cycle; formatted tag/data/parity registered.
  - REQ holds tlb_wr_vld=1 and outputs stable until tlb_wr_ack.
  - REQ->IDLE on ack; tlb_wr_done pulses in the ack cycle.
  - Minimum latency: accept to tlb_wr_vld = 2 cycles.
- tlb_wr_busy = (state != IDLE). A TTE write request while busy is ignored (protocol violation; assert in bench).
- Page size sz = {data[48],data[62:61]}. Mux selects {sel2,sel1,sel0}:
  - 000 (8K) -> 000
  - 001 (64K) -> 001
  - 011 (4M) -> 011
  - 101 (256M) -> 111
  - Any other value -> 000, and sets tlb_wr_sz_err.
- Data fields at STLB_DATA_*:
  - NFO = d[60], IE = d[59].
  - PA_39_13 = d[39:13].
  - L, CP, CV, E, P, W = d[6:1].
  - 27_22/21_16/15_13_SEL = sel2/1/0.
  - STLB_DATA_PARITY = ^data[41:0] (bits excluding the parity bit).
- Tag fields at STLB_TAG_*:
  - V = d[63], U = d[47].
  - VA_47_13 and CTXT_12_0 come from the snapshot.
  - VA_27_22_V/21_16_V/15_13_V = ~sel2/~sel1/~sel0 (VA bits below the page size are not compared).
  - Unused bits 0.
  - STLB_TAG_PARITY = XOR over tag bits {58:55,53:27,25,23:0} of the formatted tag. This is exactly the set the read-side checker covers, so readback shows no parity error.
- ack outside REQ: ignored.
- reset in FMT or REQ: immediate IDLE, tlb_wr_vld drops next edge, no done pulse.

Decomposition:
- Shared package/header (lsu.h): STLB_TAG_*/STLB_DATA_* positions, page-size encodings, state encodings.
- One sub-module, lsu_tte_fmt: combinational TTE -> {tag,data,sz_err} formatter plus parity. It is reusable by the ITLB write path.

Test Plan:
- 8K write: tag-acc[0]={VA=0x0000_1234_5678_A000>>13,ctxt=0x005}; data-in with V=1,sz=000,PA=0x12_3456_6000,P=1,W=1.
  - Expect tlb_wr_vld 2 cycles later, sels 000, all VA_V=1, idx_vld=0.
  - Expect parity matching the read-side check (inject flip -> mismatch).
- 256M data-access to idx 0x3F, sz=101 -> sels 111, VA_V bits 000, idx_vld=1, idx=0x3F.
- Hold: delay tlb_wr_ack 5 cycles -> vld and outputs stable for 5 cycles, busy=1; done pulses with tid in the ack cycle.
- Contention:
  - Same-cycle data-in tid2 plus tag-acc tid2 -> old tag used.
  - New TTE write while busy -> ignored, one write only.
- Reserved sz=010 -> sels 000, tlb_wr_sz_err=1 and stays set until reset.
- Reset asserted in REQ -> vld=0 next cycle, busy=0, no done; a subsequent write completes normally.
